axi_lite_cfg_master: RTL and testbench

Single-outstanding AXI4-Lite master that turns a simple command/response stream into AXI4-Lite write and read transactions. It is the initiator counterpart of the node's AXI-Lite configuration register slave and lets a boot sequencer or debug controller program and read back START/END address, valid-rule and connectivity registers. It also tracks stalled transactions with a cycle counter and flags a timeout.

---
 rtl/axi_lite_cfg_master_if.sv | 67 ++++++
 rtl/axi_lite_cfg_master.sv | 257 +++++++++++++++++++++++++
 tb/tb_axi_lite_cfg_master.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_cfg_master_if.sv
// ----------------------------------------------------------------------------
// axi_lite_cfg_master_if
//
// Purpose : AXI4-Lite bus bundle used between the configuration master and
//           the configuration register slave.
//
// Signals : AW  - awaddr, awvalid / awready
//           W   - wdata, wstrb, wvalid / wready
//           B   - bresp, bvalid / bready
//           AR  - araddr, arvalid / arready
//           R   - rdata, rresp, rvalid / rready
//
// Modports: master - drives address/write channels and the B/R ready lines
//           slave  - the mirror image
// ----------------------------------------------------------------------------
interface axi_lite_cfg_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;

    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;

    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_lite_cfg_master.sv
// ----------------------------------------------------------------------------
// axi_lite_cfg_master
//
// Purpose : Single-outstanding AXI4-Lite master. A command (write or read) is
//           accepted from a valid/ready stream, turned into one AXI4-Lite
//           transaction, and its result returned on a valid/ready response
//           stream. A per-transaction cycle counter flags transactions that
//           stay in flight too long; the transaction still runs to completion.
//
// Ports   : m_axi_aclk, m_axi_areset   clock, synchronous active-high reset
//           cmd_valid_i / cmd_ready_o  command handshake
//           cmd_write_i                1 = write, 0 = read
//           cmd_addr_i, cmd_wdata_i,
//           cmd_wstrb_i                command payload
//           rsp_valid_o / rsp_ready_i  response handshake
//           rsp_rdata_o                read data (0 for writes)
//           rsp_resp_o                 captured BRESP / RRESP
//           rsp_timeout_o              transaction exceeded TIMEOUT_CYCLES
//           busy_timeout_o             live: in-flight transaction is overdue
//           m_axi                      AXI4-Lite bus (master modport)
// ----------------------------------------------------------------------------
module axi_lite_cfg_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    m_axi_aclk,
    input  logic                    m_axi_areset,

    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,

    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic [1:0]              rsp_resp_o,
    output logic                    rsp_timeout_o,
    output logic                    busy_timeout_o,

    axi_lite_cfg_master_if.master   m_axi
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_RSP
    } state_t;

    // The counter holds the number of in-flight cycles already completed, so
    // the current cycle is number r_cnt+1: the overdue flag therefore fires
    // when r_cnt reaches TIMEOUT_CYCLES-1, exactly TIMEOUT_CYCLES cycles after
    // the command was accepted. It saturates there.
    localparam bit             TO_EN    = (TIMEOUT_CYCLES > 0);
    localparam int             CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]              r_resp;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_sticky;

    logic w_cmd_ready;
    logic w_cmd_accept;
    logic w_awvalid;
    logic w_wvalid;
    logic w_bready;
    logic w_arvalid;
    logic w_rready;
    logic w_rsp_valid;
    logic w_busy;
    logic w_aw_fire;
    logic w_w_fire;
    logic w_b_fire;
    logic w_r_fire;
    logic w_overdue;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of block ordering.
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_cmd_ready  = 1'b0;
        w_cmd_accept = 1'b0;
        w_awvalid    = 1'b0;
        w_wvalid     = 1'b0;
        w_bready     = 1'b0;
        w_arvalid    = 1'b0;
        w_rready     = 1'b0;
        w_rsp_valid  = 1'b0;
        w_busy       = 1'b0;
        w_aw_fire    = 1'b0;
        w_w_fire     = 1'b0;
        w_b_fire     = 1'b0;
        w_r_fire     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Held low while reset is asserted so every output reads 0.
                w_cmd_ready  = !m_axi_areset;
                w_cmd_accept = w_cmd_ready && cmd_valid_i;
                if (w_cmd_accept) begin
                    w_state_nxt = cmd_write_i ? ST_WR_REQ : ST_RD_REQ;
                end
            end

            ST_WR_REQ: begin
                // AW and W complete independently; each valid drops after its
                // own handshake and the state moves on once both are done.
                w_busy    = 1'b1;
                w_awvalid = !r_aw_done;
                w_wvalid  = !r_w_done;
                w_aw_fire = w_awvalid && m_axi.awready;
                w_w_fire  = w_wvalid && m_axi.wready;
                if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
                    w_state_nxt = ST_WR_RESP;
                end
            end

            ST_WR_RESP: begin
                w_busy   = 1'b1;
                w_bready = 1'b1;
                w_b_fire = m_axi.bvalid;
                if (w_b_fire) begin
                    w_state_nxt = ST_RSP;
                end
            end

            ST_RD_REQ: begin
                w_busy    = 1'b1;
                w_arvalid = 1'b1;
                if (m_axi.arready) begin
                    w_state_nxt = ST_RD_DATA;
                end
            end

            ST_RD_DATA: begin
                w_busy   = 1'b1;
                w_rready = 1'b1;
                w_r_fire = m_axi.rvalid;
                if (w_r_fire) begin
                    w_state_nxt = ST_RSP;
                end
            end

            ST_RSP: begin
                w_rsp_valid = 1'b1;
                if (rsp_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_overdue = TO_EN && w_busy && (r_cnt == CNT_LAST);

    // NOTE: these are plain registers, not a memory array, so all of them are
    // reset; this also keeps the AXI payload and response outputs at 0 in reset.
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rdata   <= '0;
            r_resp    <= 2'b00;
            r_cnt     <= '0;
            r_sticky  <= 1'b0;
        end else begin
            if (w_cmd_accept) begin
                r_addr    <= cmd_addr_i;
                r_wdata   <= cmd_wdata_i;
                r_wstrb   <= cmd_wstrb_i;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                r_cnt     <= '0;
                r_sticky  <= 1'b0;
            end

            if (w_aw_fire) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_fire) begin
                r_w_done <= 1'b1;
            end

            if (w_b_fire) begin
                r_resp  <= m_axi.bresp;
                r_rdata <= '0;
            end
            if (w_r_fire) begin
                r_resp  <= m_axi.rresp;
                r_rdata <= m_axi.rdata;
            end

            if (TO_EN && w_busy) begin
                if (r_cnt != CNT_LAST) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                // Latched at the end of every overdue cycle; it survives until
                // the next command so the response can report it.
                if (w_overdue) begin
                    r_sticky <= 1'b1;
                end
            end
        end
    end

    assign cmd_ready_o    = w_cmd_ready;
    assign rsp_valid_o    = w_rsp_valid;
    assign rsp_rdata_o    = r_rdata;
    assign rsp_resp_o     = r_resp;
    assign rsp_timeout_o  = r_sticky;
    assign busy_timeout_o = w_overdue;

    // AW and AR share the captured command address; payloads only change on
    // command accept, so they are stable for as long as any valid is high.
    assign m_axi.awaddr  = r_addr;
    assign m_axi.awvalid = w_awvalid;
    assign m_axi.wdata   = r_wdata;
    assign m_axi.wstrb   = r_wstrb;
    assign m_axi.wvalid  = w_wvalid;
    assign m_axi.bready  = w_bready;
    assign m_axi.araddr  = r_addr;
    assign m_axi.arvalid = w_arvalid;
    assign m_axi.rready  = w_rready;

endmodule

// File: tb/tb_axi_lite_cfg_master.sv
// ----------------------------------------------------------------------------
// tb_axi_lite_cfg_master
//
// Purpose : Self-checking bench for axi_lite_cfg_master (TIMEOUT_CYCLES = 8).
//           A cycle-based loop plays the AXI slave with per-transaction
//           channel delays and checks every cycle against the channel-level
//           rules: each valid is high from the first cycle after accept until
//           its own handshake, B/R ready only after the request side is done,
//           the response appears the cycle after B/R completes and carries the
//           slave's values, and the overdue flags follow the elapsed cycle
//           count since accept.
// ----------------------------------------------------------------------------
module tb_axi_lite_cfg_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          rsp_timeout;
    logic          busy_timeout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi_lite_cfg_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axi_lite_cfg_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .m_axi_aclk     (clk),
        .m_axi_areset   (rst),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_write_i    (cmd_write),
        .cmd_addr_i     (cmd_addr),
        .cmd_wdata_i    (cmd_wdata),
        .cmd_wstrb_i    (cmd_wstrb),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_resp_o     (rsp_resp),
        .rsp_timeout_o  (rsp_timeout),
        .busy_timeout_o (busy_timeout),
        .m_axi          (axi)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy_timeout}
    function automatic logic [7:0] ctl_now();
        return {cmd_ready, axi.awvalid, axi.wvalid, axi.bready,
                axi.arvalid, axi.rready, rsp_valid, busy_timeout};
    endfunction

    task automatic slave_idle();
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rresp   = 2'b00;
        axi.rdata   = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 64'(ctl_now()), 64'd0);
        check({tag, "_rsp"}, {29'd0, rsp_timeout, rsp_resp, rsp_rdata}, 64'd0);
        check({tag, "_addr"}, {axi.awaddr, axi.araddr}, 64'd0);
        check({tag, "_wdat"}, {28'd0, axi.wstrb, axi.wdata}, 64'd0);
    endtask

    task automatic pulse_reset(input string tag);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        slave_idle();
        @(posedge clk);
        @(negedge clk);
        check_all_zero(tag);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_ready_after"}, 64'(cmd_ready), 64'd1);
    endtask

    // One complete command/response exchange. Called and returns at a negedge
    // with the DUT idle. Delays count cycles the slave waits after the
    // relevant precondition before answering. abort_at > 0 resets the DUT in
    // that cycle after accept instead of finishing.
    task automatic run_txn(input bit wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                           input logic [1:0] resp, input logic [DW-1:0] rdat,
                           input int aw_dly, input int w_dly, input int b_dly,
                           input int ar_dly, input int r_dly, input int rsp_dly,
                           input int abort_at);
        bit aw_f = 0, w_f = 0, b_f = 0, ar_f = 0, r_f = 0, done = 0;
        bit aw_fire, w_fire, b_fire, ar_fire, r_fire, rsp_fire;
        bit exp_rsp, exp_to;
        int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0, rsp_c = 0;
        int j_rsp = 0;
        logic [7:0] exp_ctl;

        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = strb;
        @(posedge clk);
        @(negedge clk);
        // Scramble the command bus: the DUT must work from its captured copy.
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_wstrb = SW'($urandom);

        for (int j = 1; j <= 300 && !done; j++) begin
            exp_rsp = b_f || r_f;
            if (exp_rsp && j_rsp == 0) j_rsp = j;
            exp_to  = (j_rsp != 0) && ((j_rsp - 1) >= TO);
            exp_ctl = {1'b0,
                       wr && !aw_f,
                       wr && !w_f,
                       wr && aw_f && w_f && !b_f,
                       !wr && !ar_f,
                       !wr && ar_f && !r_f,
                       exp_rsp,
                       !exp_rsp && (j >= TO)};
            check("ctl", 64'(ctl_now()), 64'(exp_ctl));
            if (axi.awvalid) check("awaddr", 64'(axi.awaddr), 64'(addr));
            if (axi.wvalid)  check("wdata_wstrb", {28'd0, axi.wstrb, axi.wdata}, {28'd0, strb, wdata});
            if (axi.arvalid) check("araddr", 64'(axi.araddr), 64'(addr));
            if (rsp_valid)   check("rsp_payload", {29'd0, rsp_timeout, rsp_resp, rsp_rdata},
                                   {29'd0, exp_to, resp, (wr ? 32'd0 : rdat)});

            if (j == abort_at) begin
                pulse_reset("mid_rst");
                return;
            end

            // Slave behaviour for the coming edge.
            axi.awready = axi.awvalid && (aw_c >= aw_dly);
            if (axi.awvalid) aw_c++;
            axi.wready  = axi.wvalid && (w_c >= w_dly);
            if (axi.wvalid) w_c++;
            axi.bvalid  = aw_f && w_f && !b_f && (b_c >= b_dly);
            if (aw_f && w_f && !b_f) b_c++;
            axi.bresp   = axi.bvalid ? resp : 2'($urandom);
            axi.arready = axi.arvalid && (ar_c >= ar_dly);
            if (axi.arvalid) ar_c++;
            axi.rvalid  = ar_f && !r_f && (r_c >= r_dly);
            if (ar_f && !r_f) r_c++;
            axi.rdata   = axi.rvalid ? rdat : DW'($urandom);
            axi.rresp   = axi.rvalid ? resp : 2'($urandom);
            rsp_ready   = rsp_valid && (rsp_c >= rsp_dly);
            if (rsp_valid) rsp_c++;

            aw_fire  = axi.awvalid && axi.awready;
            w_fire   = axi.wvalid && axi.wready;
            b_fire   = axi.bvalid && axi.bready;
            ar_fire  = axi.arvalid && axi.arready;
            r_fire   = axi.rvalid && axi.rready;
            rsp_fire = rsp_valid && rsp_ready;

            @(posedge clk);
            aw_f = aw_f || aw_fire;
            w_f  = w_f || w_fire;
            b_f  = b_f || b_fire;
            ar_f = ar_f || ar_fire;
            r_f  = r_f || r_fire;
            done = rsp_fire;
            @(negedge clk);
            slave_idle();
            rsp_ready = 1'b0;
        end

        if (!done) begin
            check("txn_completed", 64'd0, 64'd1);
            pulse_reset("recover");
        end else if (aw_dly == 0 && w_dly == 0 && b_dly == 0 && ar_dly == 0 && r_dly == 0) begin
            check("latency", 64'(j_rsp), 64'd3);
        end
    endtask

    initial begin
        bit wr;
        int mx;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b0;
        slave_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", 64'(cmd_ready), 64'd1);

        // Write, slave always ready.
        run_txn(1, 32'h04, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        // W completes first, AW held for 5 cycles; then the reverse order.
        run_txn(1, 32'h08, 32'hCAFEF00D, 4'h3, 2'b00, 32'h0, 5, 0, 0, 0, 0, 0, 0);
        run_txn(1, 32'h0C, 32'h0BADF00D, 4'hC, 2'b00, 32'h0, 0, 5, 0, 0, 0, 0, 0);
        // Readback, then a read with backpressure on every stage.
        run_txn(0, 32'h04, 32'h0, 4'h0, 2'b00, 32'h12345678, 0, 0, 0, 0, 0, 0, 0);
        run_txn(0, 32'h10, 32'h0, 4'h0, 2'b00, 32'hA5A55A5A, 0, 0, 0, 2, 3, 4, 0);
        // Timeout: B withheld 20 cycles, then a clean command clears the flag.
        run_txn(1, 32'h14, 32'h00000001, 4'h1, 2'b00, 32'h0, 0, 0, 20, 0, 0, 0, 0);
        run_txn(1, 32'h18, 32'h00000002, 4'hF, 2'b00, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        // Timeout boundary: 8 cycles in flight flags, 7 does not.
        run_txn(1, 32'h1C, 32'h00000003, 4'hF, 2'b00, 32'h0, 0, 0, 6, 0, 0, 0, 0);
        run_txn(1, 32'h1C, 32'h00000004, 4'hF, 2'b00, 32'h0, 0, 0, 5, 0, 0, 0, 0);
        // Error responses pass through.
        run_txn(1, 32'h20, 32'h55AA55AA, 4'hF, 2'b10, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        run_txn(0, 32'h24, 32'h0, 4'h0, 2'b11, 32'h87654321, 0, 0, 0, 0, 0, 0, 0);
        // Reset while waiting in the read-data phase.
        run_txn(0, 32'h28, 32'h0, 4'h0, 2'b00, 32'h11111111, 0, 0, 0, 0, 10, 0, 4);
        run_txn(0, 32'h2C, 32'h0, 4'h0, 2'b01, 32'h22222222, 0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 120; k++) begin
            wr = 1'($urandom);
            mx = ($urandom_range(0, 7) == 0) ? 12 : 3;
            run_txn(wr, {$urandom_range(0, 255), 2'b00} , $urandom, 4'($urandom),
                    2'($urandom), $urandom,
                    $urandom_range(0, mx), $urandom_range(0, mx), $urandom_range(0, mx),
                    $urandom_range(0, mx), $urandom_range(0, mx), $urandom_range(0, 3), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
